// File: rtl/dmem_ctrl.sv
// Lane-banked data memory controller: byte/half/word loads and stores with
// optional two-beat handling of accesses that straddle a word boundary.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready; an accepted access performs its only (or first) beat
// S_SPLIT | second beat of a straddling access on word W+1, lanes from 0
module dmem_ctrl #(
   parameter int BITS     = 8,
   parameter int LANES    = 4,
   parameter int ADDRW    = 13,
   parameter int SPLIT_EN = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req,
   input  logic                              we,
   input  logic [1:0]                        size,
   input  logic                              uns,
   input  logic [ADDRW+$clog2(LANES)-1:0]    addr,
   input  logic [LANES*BITS-1:0]             wdata,
   output logic                              ready,
   output logic                              rvalid,
   output logic [LANES*BITS-1:0]             rdata,
   output logic                              err
);
   localparam int LB    = $clog2(LANES);
   localparam int DEPTH = 1 << ADDRW;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SPLIT = 1'b1;

   logic [0:0]            state;
   logic [LB-1:0]         lane_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic                  we_q;
   logic [ADDRW-1:0]      word_q;
   logic [LANES*BITS-1:0] wdata_q;
   logic                  rvalid_q;
   logic                  err_q;

   logic [LB-1:0]         lane_in;
   logic [ADDRW-1:0]      word_in;
   int                    n_in;
   int                    n_q;
   int                    span;
   logic                  mis;
   logic                  illegal;
   logic                  acc;

   logic [LANES-1:0]      lane_en;
   logic                  acc_we;
   logic [ADDRW-1:0]      lane_word  [LANES];
   logic [BITS-1:0]       lane_wbyte [LANES];

   logic [BITS-1:0]       mem   [LANES][DEPTH];
   logic [BITS-1:0]       rlane [LANES];
   logic                  sign;

   assign lane_in = addr[LB-1:0];
   assign word_in = addr[LB+ADDRW-1:LB];
   assign ready   = (state == S_IDLE);
   assign acc     = req && ready && !rst;
   assign rvalid  = rvalid_q;
   assign err     = err_q;

   always_comb begin
      n_in    = 1 << int'(size);
      n_q     = 1 << int'(size_q);
      span    = int'(lane_in) + n_in;
      mis     = span > LANES;
      illegal = (size == 2'd3) || (n_in > LANES) || (mis && (SPLIT_EN == 0));
   end

   // Per-lane access decode for the current beat; only one beat runs per cycle.
   always_comb begin
      lane_en = '0;
      acc_we  = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         lane_word[l]  = '0;
         lane_wbyte[l] = '0;
      end
      if (state == S_SPLIT) begin
         acc_we = we_q;
         for (int l = 0; l < LANES; l++) begin
            if (l < int'(lane_q) + n_q - LANES) begin
               lane_en[l]    = 1'b1;
               lane_word[l]  = word_q + ADDRW'(1);
               lane_wbyte[l] = wdata_q[(LANES - int'(lane_q) + l)*BITS +: BITS];
            end
         end
      end else if (acc && !illegal) begin
         acc_we = we;
         for (int l = 0; l < LANES; l++) begin
            if ((l >= int'(lane_in)) && (l < span)) begin
               lane_en[l]    = 1'b1;
               lane_word[l]  = word_in;
               lane_wbyte[l] = wdata[(l - int'(lane_in))*BITS +: BITS];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         if (lane_en[l] && acc_we) mem[l][lane_word[l]] <= lane_wbyte[l];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l < LANES; l++) rlane[l] <= '0;
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (lane_en[l] && !acc_we) rlane[l] <= mem[l][lane_word[l]];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         lane_q   <= '0;
         size_q   <= '0;
         uns_q    <= 1'b0;
         we_q     <= 1'b0;
         word_q   <= '0;
         wdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (acc) begin
                  lane_q  <= lane_in;
                  size_q  <= size;
                  uns_q   <= uns;
                  we_q    <= we;
                  word_q  <= word_in;
                  wdata_q <= wdata;
                  if (illegal)  err_q    <= 1'b1;
                  else if (mis) state    <= S_SPLIT;
                  else          rvalid_q <= !we;
               end
            end
            S_SPLIT: begin
               state    <= S_IDLE;
               rvalid_q <= !we_q;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Byte i of the result always lives in lane (lane_q + i) mod LANES.
   always_comb begin
      rdata = '0;
      sign  = 1'b0;
      if (rvalid_q) begin
         sign = rlane[lane_q + LB'(n_q - 1)][BITS-1] & ~uns_q;
         for (int i = 0; i < LANES; i++) begin
            if (i < n_q) rdata[i*BITS +: BITS] = rlane[lane_q + LB'(i)];
            else         rdata[i*BITS +: BITS] = {BITS{sign}};
         end
      end
   end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized bench for dmem_ctrl against a flat byte-array memory model,
// plus directed scenarios with literal expectations.
module tb_dmem_ctrl;
   localparam int AW  = 15;
   localparam int TOT = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req = 1'b0, we = 1'b0, uns = 1'b0;
   logic [1:0]    size = 2'd0;
   logic [AW-1:0] addr = '0;
   logic [31:0]   wdata = '0;
   logic          ready, rvalid, err;
   logic [31:0]   rdata;

   logic          req0 = 1'b0, we0 = 1'b0, uns0 = 1'b0;
   logic [1:0]    size0 = 2'd0;
   logic [AW-1:0] addr0 = '0;
   logic [31:0]   wdata0 = '0;
   logic          ready0, rvalid0, err0;
   logic [31:0]   rdata0;

   dmem_ctrl #(.BITS(8), .LANES(4), .ADDRW(13), .SPLIT_EN(1)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid),
      .rdata(rdata), .err(err));

   dmem_ctrl #(.BITS(8), .LANES(4), .ADDRW(13), .SPLIT_EN(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .size(size0), .uns(uns0),
      .addr(addr0), .wdata(wdata0), .ready(ready0), .rvalid(rvalid0),
      .rdata(rdata0), .err(err0));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]  mm [TOT];
   bit          exp_rv   [int];
   logic [31:0] exp_rd   [int];
   bit          exp_err  [int];
   bit          exp_busy [int];
   logic [31:0] lit      [int];
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
      end
   endtask

   function automatic logic [31:0] mload(input int a, input int sz, input bit u);
      int n;
      logic [31:0] v;
      n = 1 << sz;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[(a + i) % TOT];
      if (!u && mm[(a + n - 1) % TOT][7])
         for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic mstore(input int a, input logic [31:0] wd, input int nbytes);
      for (int i = 0; i < nbytes; i++) mm[(a + i) % TOT] = wd[8*i +: 8];
   endtask

   // Called at a clock edge + 1; returns one edge after acceptance (+1).
   task automatic acc_op(input bit w, input int sz, input bit u, input int a,
                         input logic [31:0] wd, input bit has_lit,
                         input logic [31:0] litv, output int ac);
      int  n, guard, lat;
      bit  ill, spl;
      req = 1'b1; we = w; size = 2'(sz); uns = u; addr = AW'(a); wdata = wd;
      guard = 0;
      while (!ready && guard < 8) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!ready) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout cyc=%0d actual=0 required=1", cyc);
      end
      ac  = cyc + 1;
      n   = 1 << sz;
      ill = (sz == 3);
      spl = !ill && ((a % 4) + n > 4);
      lat = spl ? 1 : 0;
      if (ill) exp_err[ac] = 1'b1;
      else begin
         if (spl) exp_busy[ac] = 1'b1;
         if (w) mstore(a, wd, n);
         else begin
            exp_rv[ac + lat] = 1'b1;
            exp_rd[ac + lat] = mload(a, sz, u);
            if (has_lit) lit[ac + lat] = litv;
         end
      end
      @(posedge clk); #1;
      req   = 1'b0;
      we    = 1'($urandom);
      size  = 2'($urandom);
      uns   = 1'($urandom);
      addr  = AW'($urandom);
      wdata = $urandom;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         check("rst_ready",  32'(ready),  32'd1);
         check("rst_rvalid", 32'(rvalid), 32'd0);
         check("rst_rdata",  rdata,       32'd0);
         check("rst_err",    32'(err),    32'd0);
      end else begin
         check("ready",  32'(ready),  exp_busy.exists(cyc) ? 32'd0 : 32'd1);
         check("rvalid", 32'(rvalid), exp_rv.exists(cyc)   ? 32'd1 : 32'd0);
         check("rdata",  rdata,       exp_rd.exists(cyc)   ? exp_rd[cyc] : 32'd0);
         check("err",    32'(err),    exp_err.exists(cyc)  ? 32'd1 : 32'd0);
         if (lit.exists(cyc)) check("literal", rdata, lit[cyc]);
      end
   end

   task automatic op0(input bit w, input int sz, input int a, input logic [31:0] wd);
      req0 = 1'b1; we0 = w; size0 = 2'(sz); uns0 = 1'b1; addr0 = AW'(a); wdata0 = wd;
      @(posedge clk); #1;
      req0 = 1'b0;
   endtask

   function automatic int raddr();
      if ($urandom_range(0, 4) == 0) return TOT - 8 + int'($urandom_range(0, 7));
      return int'($urandom_range(0, 63));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   initial begin
      int ac;
      logic [31:0] r;
      logic [7:0]  old3c, old40;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 192; i += 4) acc_op(1'b1, 2, 1'b0, i, $urandom, 1'b0, 32'd0, ac);
      for (int i = TOT - 16; i < TOT; i += 4) acc_op(1'b1, 2, 1'b0, i, $urandom, 1'b0, 32'd0, ac);

      acc_op(1'b1, 2, 1'b0, 'h10, 32'hDEADBEEF, 1'b0, 32'd0, ac);
      acc_op(1'b0, 2, 1'b0, 'h10, 32'd0, 1'b1, 32'hDEADBEEF, ac);

      r = $urandom;
      acc_op(1'b1, 0, 1'b0, 'h21, {r[23:0], 8'h80}, 1'b0, 32'd0, ac);
      acc_op(1'b0, 0, 1'b0, 'h21, 32'd0, 1'b1, 32'hFFFFFF80, ac);
      acc_op(1'b0, 0, 1'b1, 'h21, 32'd0, 1'b1, 32'h00000080, ac);
      acc_op(1'b0, 2, 1'b0, 'h20, 32'd0, 1'b0, 32'd0, ac);

      acc_op(1'b1, 2, 1'b0, 'h0E, 32'h11223344, 1'b0, 32'd0, ac);
      acc_op(1'b0, 0, 1'b1, 'h0E, 32'd0, 1'b1, 32'h44, ac);
      acc_op(1'b0, 0, 1'b1, 'h0F, 32'd0, 1'b1, 32'h33, ac);
      acc_op(1'b0, 0, 1'b1, 'h10, 32'd0, 1'b1, 32'h22, ac);
      acc_op(1'b0, 0, 1'b1, 'h11, 32'd0, 1'b1, 32'h11, ac);
      acc_op(1'b0, 2, 1'b0, 'h0E, 32'd0, 1'b1, 32'h11223344, ac);

      acc_op(1'b1, 1, 1'b0, TOT - 1, 32'h0000A5B6, 1'b0, 32'd0, ac);
      acc_op(1'b0, 0, 1'b1, TOT - 1, 32'd0, 1'b1, 32'hB6, ac);
      acc_op(1'b0, 0, 1'b1, 0, 32'd0, 1'b1, 32'hA5, ac);
      acc_op(1'b0, 1, 1'b0, TOT - 1, 32'd0, 1'b1, 32'hFFFFA5B6, ac);

      acc_op(1'b1, 3, 1'b0, 'h40, $urandom, 1'b0, 32'd0, ac);
      acc_op(1'b0, 2, 1'b0, 'h40, 32'd0, 1'b0, 32'd0, ac);

      // Build without splitting: misaligned access is rejected, aligned works.
      op0(1'b1, 2, 'h04, 32'h12345678);
      @(negedge clk);
      check("nosplit_store_rvalid", 32'(rvalid0), 32'd0);
      op0(1'b0, 2, 'h02, 32'd0);
      @(negedge clk);
      check("nosplit_err",    32'(err0),    32'd1);
      check("nosplit_rvalid", 32'(rvalid0), 32'd0);
      check("nosplit_rdata",  rdata0,       32'd0);
      check("nosplit_ready",  32'(ready0),  32'd1);
      op0(1'b1, 2, 'h05, 32'hFFFFFFFF);
      @(negedge clk);
      check("nosplit_store_err", 32'(err0), 32'd1);
      op0(1'b0, 2, 'h04, 32'd0);
      @(negedge clk);
      check("nosplit_load_err",    32'(err0),    32'd0);
      check("nosplit_load_rvalid", 32'(rvalid0), 32'd1);
      check("nosplit_load_rdata",  rdata0,       32'h12345678);
      @(posedge clk); #1;

      for (int k = 0; k < 400; k++) begin
         int sz;
         sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         acc_op(1'($urandom), sz, 1'($urandom), raddr(), $urandom, 1'b0, 32'd0, ac);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      // Reset during beat 2 of a split store: only the beat-1 bytes land.
      old3c = mm['h3C];
      old40 = mm['h40];
      acc_op(1'b1, 2, 1'b0, 'h3D, 32'hCAFEF00D, 1'b0, 32'd0, ac);
      rst = 1'b1;
      mm['h40] = old40;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      acc_op(1'b0, 2, 1'b0, 'h3C, 32'd0, 1'b1, {24'hFEF00D, old3c}, ac);
      acc_op(1'b0, 0, 1'b1, 'h40, 32'd0, 1'b1, {24'd0, old40}, ac);

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter BITS, default 8: lane width in bits.
REQ-002 Parameter LANES, default 4: lanes (byte banks) per word; power of 2, at least 2.
REQ-003 Parameter ADDRW, default 13: word-address width; each lane holds 2**ADDRW entries.
REQ-004 Parameter SPLIT_EN, default 1: 1 = misaligned accesses run as two beats; 0 = misaligned accesses raise err.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port req, input, 1: access request.
REQ-008 Port we, input, 1: 1 = store, 0 = load.
REQ-009 Port size, input, 2: log2 of the access size in lanes (0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes).
REQ-010 Port uns, input, 1: 1 = zero-extend load data, 0 = sign-extend it.
REQ-011 Port addr, input, ADDRW+log2(LANES): lane (byte) address.
REQ-012 Port wdata, input, LANES*BITS: store data, right-aligned.
REQ-013 Port ready, output, 1: request is accepted at a rising edge when req && ready.
REQ-014 Port rvalid, output, 1: one-cycle pulse marking rdata valid.
REQ-015 Port rdata, output, LANES*BITS: load data, right-aligned and extended.
REQ-016 Port err, output, 1: one-cycle pulse on a rejected request.

Function
REQ-017 Storage: LANES independent single-port lane RAMs of BITS x 2**ADDRW; lane index = addr[log2(LANES)-1:0]; word index = upper addr bits.
REQ-018 FSM states: IDLE and SPLIT; ready = 1 only in IDLE.
REQ-019 Illegal request = size reserved (3) or 2**size > LANES; at accept, no lane is accessed, err pulses the next cycle, rvalid stays 0, state stays IDLE.
REQ-020 Fits in one word (lane + 2**size <= LANES): all lanes access at the accept edge; store writes the enabled lanes only; load results appear next cycle with rvalid = 1.
REQ-021 Misaligned with SPLIT_EN = 1: beat 1 at the accept edge accesses lanes lane..LANES-1 of word W; state moves to SPLIT.
REQ-022 Beat 2 at the next edge accesses lanes 0..(lane+2**size-LANES-1) of word W+1; state moves back to IDLE; for loads, rvalid pulses the cycle after beat 2.
REQ-023 W+1 wraps modulo 2**ADDRW: the top word wraps to word 0.
REQ-024 Misaligned with SPLIT_EN = 0: treated as illegal, per REQ-019.
REQ-025 Store lane data: the low-order bytes of wdata go to the lowest addresses, so beat 1 takes the low part and beat 2 the remainder; request inputs are captured at accept and need not be held during SPLIT.
REQ-026 Load assembly: bytes are ordered little-endian and right-aligned; bits above 2**size*BITS are filled with the sign bit of the top byte, or with 0 when uns = 1.
REQ-027 Stores never assert rvalid; rdata = 0 whenever rvalid = 0.
REQ-028 Full-word aligned load latency is 1 cycle; split load latency is 2 cycles; back-to-back aligned accepts are allowed every cycle.
REQ-029 A load to a lane written by the immediately preceding accepted store returns the new data.

Reset
REQ-030 While rst = 1: state = IDLE; ready = 1; rvalid, err and rdata = 0; internal capture registers are cleared.
REQ-031 RAM contents are not reset.
REQ-032 Reset during SPLIT abandons beat 2; the beat-1 write stands.
REQ-033 The first request is accepted at the first rising edge after rst deasserts.

Verification
REQ-034 Aligned word: store 0xDEADBEEF @0x10, then load size=2 @0x10 -> rvalid one cycle after accept, rdata 0xDEADBEEF.
REQ-035 Sub-word sign: store byte 0x80 @0x21; load size=0, uns=0 -> 0xFFFFFF80; the same load with uns=1 -> 0x00000080; lanes 0, 2 and 3 of word 8 are unchanged.
REQ-036 Split: store word 0x11223344 @0x0E.
- Expected: ready low for one cycle; word 3 lanes 2-3 = 0x44, 0x33; word 4 lanes 0-1 = 0x22, 0x11.
- A word load @0x0E returns 0x11223344 two cycles after accept.
REQ-037 Wrap: halfword store 0xA5B6 @ top byte (2**(ADDRW+2)-1) -> 0xB6 at top byte, 0xA5 at byte 0.
REQ-038 Errors: size=3 request -> err pulse, no write.
- SPLIT_EN = 0 build: word load @0x02 -> err pulse, rvalid = 0.
REQ-039 Reset mid-SPLIT: assert rst during beat 2 of a split store.
- Expected: only the beat-1 lanes are written; ready = 1 after reset; the next aligned load works.
